mux8_1_tdm: RTL
===============

# mux8_1_tdm

Time-division 8:1 multiplexer that serializes eight single-bit lanes onto one line. It is the transmit end for the 1:8 demultiplexer: its `Output`/`Sel`/`Valid` drive the demux `Input`/`Sel`/`Enable` directly, so a loopback reproduces the eight lanes. It snapshots all lanes at each frame start and scans them in order, one slot per lane, using a programmable slot length.

## Interface
- `SLOT_CYCLES`, default 1: clock cycles per slot. Legal range is 1..16.
- `Clk` in 1: single clock. All logic updates on the rising edge.
- `Reset` in 1: synchronous, active-high.
- `Enable` in 1: request to transmit frames. Sampled only at frame boundaries.
- `Input1`..`Input8` in 1 each: source lanes. `Input1` maps to `Sel`=0 and `Input8` maps to `Sel`=7.
- `Output` out 1: the serialized bit, registered.
- `Sel` out 3: the current lane index, registered.
- `Valid` out 1: high while a data slot is on `Output`.
- `FrameStart` out 1: high during every cycle of slot 0.
- `ParitySlot` out 1: exists only with `TDM_PARITY_EN`. High during the parity slot.

## Operation
- **Reset values:** `Output`=0, `Sel`=0, `Valid`=0, `FrameStart`=0, `ParitySlot`=0. Internally, state is IDLE, the snapshot is 8'h00, and the slot and cycle counters are 0.
- **States:**
  - IDLE: outputs are held at their reset values.
  - RUN: a frame is being transmitted.
- **IDLE → RUN:** occurs at an edge where `Enable`=1. At that same edge:
  - snap[7:0] ← {Input8..Input1};
  - slot ← 0;
  - cycle ← 0.
- **RUN, each cycle:**
  - `Output` = snap[slot];
  - `Sel` = slot;
  - `Valid` = 1;
  - `FrameStart` = (slot==0).
- **Counters:**
  - `cycle` increments each cycle. When `cycle`==SLOT_CYCLES-1 it wraps to 0 and `slot` increments.
  - `slot` runs 0..7. There is no wrap inside a frame.
- **Frame boundary:** the last cycle of slot 7 (or of the parity slot when enabled).
  - If `Enable`=1, resnapshot the lanes and start slot 0 on the next cycle with no gap cycle.
  - Otherwise return to IDLE.
- **Enable deasserted mid-frame:** ignored. The frame always completes.
- **Input changes mid-frame:** have no effect until the next snapshot.
- **Reset mid-frame:** the next cycle shows reset values. There is no partial-frame resume.

## Timing
- Latency: lanes are captured at edge k, and slot 0 is visible on the outputs after edge k.
- Data frame length = 8·SLOT_CYCLES cycles. With `TDM_PARITY_EN` it is 9·SLOT_CYCLES.
- Back-to-back frames are seamless. `FrameStart` is reasserted immediately after the last slot.
- All outputs come directly from flops. There is no combinational path from any input to any output.
- `Enable` rising during the frame's final cycle is honored at that same boundary edge.

## Configuration
- Macro: `TDM_PARITY_EN`.
- **Defined:**
  - A ninth slot (index 8) follows slot 7. In it, `Output` = ^snap (even parity), `Sel`=0, `Valid`=0, `ParitySlot`=1.
  - `Valid`=0 makes a downstream demux emit zeros during this slot.
  - The slot counter is 4 bits wide.
- **Undefined:** 8-slot frames, no `ParitySlot` port, and a 3-bit slot counter.

## Structure
- Package `mux_tdm_pkg` holds:
  - the state enum {IDLE, RUN};
  - `NUM_LANES`=8, `SEL_W`=3, `PARITY_SLOT`=8;
  - the `SLOT_CYCLES` legal limit, 16.
- One sub-module, `tdm_slot_timer`:
  - `SLOT_CYCLES` divider with `Clk`, `Reset` and a `Run` input;
  - emits a one-cycle `SlotEnd` pulse on the last cycle of each slot.
- The top level holds the FSM, the snapshot register, the slot counter and the output registers.

## Test plan
- **Reset mid-frame:** SLOT_CYCLES=1, lanes=8'b1010_0110, `Enable` held high. Expect:
  - `Output` sequence 0,1,1,0,0,1,0,1 with `Sel` 0..7;
  - `FrameStart` on slot 0 only;
  - the next frame starting with no gap;
  - after `Reset`=1 asserted during slot 3, all outputs 0 on the following cycle.
- **Slot length 3:** SLOT_CYCLES=3, `Enable` pulsed for one cycle. Expect:
  - each slot held exactly 3 cycles and the frame lasting 24 cycles;
  - a return to IDLE with `Valid`=0 on cycle 25.
- **Lanes toggle mid-frame:** all lanes go from 8'h00 to 8'hFF at slot 4. Expect the current frame to still output all zeros, and the next frame (with `Enable`=1) to output all ones.
- **Enable drop:** `Enable` dropped at slot 2 and reasserted on the final cycle of slot 7. Expect the frame to complete and a new frame to start immediately.
- **Loopback:** connect `Output`→demux `Input`, `Sel`→demux `Sel`, `Valid`→demux `Enable`. Expect the demux `Output1..8` pulses to reproduce lanes 8'h5A over one frame.
- **Parity (`TDM_PARITY_EN`):** lanes=8'b0000_0111. Expect:
  - slot 8 with `Output`=1, `ParitySlot`=1, `Valid`=0;
  - a frame length of 9 cycles.

Source files
------------

// File: rtl/mux_tdm_pkg.sv
// Shared types and constants for the TDM 8:1 serializer.
// State enum, lane/select widths, parity slot index, slot length limit.
package mux_tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NUM_LANES       = 8;
  localparam int SEL_W           = 3;
  localparam int PARITY_SLOT     = 8;
  localparam int SLOT_CYCLES_MAX = 16;
  localparam int CYC_W           = 4;

endpackage

// File: rtl/tdm_slot_timer.sv
// Slot length divider: counts SLOT_CYCLES clocks per slot while Run is high.
// Ports: Clk, Reset (sync, high), Run in; SlotEnd out (last cycle of a slot).
module tdm_slot_timer
  import mux_tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  output logic SlotEnd
);

  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(SLOT_CYCLES - 1);

  logic [CYC_W-1:0] cyc_q;
  logic [CYC_W-1:0] cyc_d;

  assign SlotEnd = Run && (cyc_q == LAST_CYC);

  // Counter rests at 0 while idle so the first slot starts full length.
  always_comb begin
    cyc_d = cyc_q;
    if (!Run || SlotEnd) begin
      cyc_d = '0;
    end else begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

endmodule

// File: rtl/mux8_1_tdm.sv
// Time-division 8:1 serializer: snapshots Input1..8 per frame, scans one lane per slot.
// In: Clk, Reset, Enable, Input1..8. Out: Output, Sel[2:0], Valid, FrameStart,
// ParitySlot (only with TDM_PARITY_EN, which adds a ninth even-parity slot).
module mux8_1_tdm
  import mux_tdm_pkg::*;
#(
  parameter int SLOT_CYCLES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Input1,
  input  logic             Input2,
  input  logic             Input3,
  input  logic             Input4,
  input  logic             Input5,
  input  logic             Input6,
  input  logic             Input7,
  input  logic             Input8,
  output logic             Output,
  output logic [SEL_W-1:0] Sel,
  output logic             Valid,
`ifdef TDM_PARITY_EN
  output logic             ParitySlot,
`endif
  output logic             FrameStart
);

`ifdef TDM_PARITY_EN
  localparam int SLOT_W = 4;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PARITY_SLOT);
`else
  localparam int SLOT_W = 3;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_LANES - 1);
`endif

  state_e                 state_q, state_d;
  logic [NUM_LANES-1:0]   snap_q, snap_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [NUM_LANES-1:0]   lanes;
  logic                   slot_end;
  logic                   is_par;
  logic                   out_d, valid_d, fs_d;
  logic [SEL_W-1:0]       sel_d;
`ifdef TDM_PARITY_EN
  logic                   ps_d;
`endif

  assign lanes = {Input8, Input7, Input6, Input5,
                  Input4, Input3, Input2, Input1};

  tdm_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .Run     (state_q == RUN),
    .SlotEnd (slot_end)
  );

  // Next state; output flops are loaded from the next state so they
  // present the slot that begins at the same edge.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    slot_d  = slot_q;
    unique case (state_q)
      IDLE: begin
        if (Enable) begin
          state_d = RUN;
          snap_d  = lanes;
          slot_d  = '0;
        end
      end
      RUN: begin
        if (slot_end) begin
          if (slot_q == LAST_SLOT) begin
            slot_d = '0;
            if (Enable) begin
              snap_d = lanes;
            end else begin
              state_d = IDLE;
            end
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef TDM_PARITY_EN
    is_par = (slot_d == SLOT_W'(PARITY_SLOT));
    ps_d   = 1'b0;
`else
    is_par = 1'b0;
`endif
    out_d   = 1'b0;
    sel_d   = '0;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    if (state_d == RUN) begin
      if (is_par) begin
        out_d = ^snap_d;
`ifdef TDM_PARITY_EN
        ps_d  = 1'b1;
`endif
      end else begin
        sel_d   = slot_d[SEL_W-1:0];
        out_d   = snap_d[slot_d[SEL_W-1:0]];
        valid_d = 1'b1;
        fs_d    = (slot_d == '0);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      slot_q     <= '0;
      Output     <= 1'b0;
      Sel        <= '0;
      Valid      <= 1'b0;
      FrameStart <= 1'b0;
`ifdef TDM_PARITY_EN
      ParitySlot <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      slot_q     <= slot_d;
      Output     <= out_d;
      Sel        <= sel_d;
      Valid      <= valid_d;
      FrameStart <= fs_d;
`ifdef TDM_PARITY_EN
      ParitySlot <= ps_d;
`endif
    end
  end

endmodule
